// File: rtl/lab61soc_pkg.sv
// lab61soc_pkg: shared FSM encoding and default parameters for the button poller
package lab61soc_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam int DEF_POLL_DIV = 50000;
  localparam int DEF_STABLE_SAMPLES = 4;
  localparam int DEF_ACTIVE_LOW = 1;
  localparam logic [1:0] DEF_POLL_ADDR = 2'd0;
endpackage

// File: rtl/lab61soc_debounce.sv
// lab61soc_debounce: accepts a level after STABLE_SAMPLES equal samples and emits edge pulses
module lab61soc_debounce
  import lab61soc_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_valid,
  input  logic sample,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);
  localparam logic [3:0] STABLE = 4'(STABLE_SAMPLES);
  logic candidate;
  logic [3:0] stable_cnt;
  logic [3:0] next_cnt;
  logic accept;
  always_comb next_cnt = (sample != candidate) ? 4'd1 : (stable_cnt == STABLE) ? stable_cnt : stable_cnt + 4'd1;
  assign accept = sample_valid && next_cnt == STABLE && sample != pressed;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      candidate <= 1'b0;
      stable_cnt <= 4'd0;
      pressed <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse <= accept && sample;
      release_pulse <= accept && !sample;
      if (sample_valid) begin
        candidate <= sample;
        stable_cnt <= next_cnt;
      end
      if (accept) pressed <= sample;
    end
  end
endmodule

// File: rtl/lab61soc_button_poller.sv
// lab61soc_button_poller: periodic Avalon-MM reader of a button register with debounce and press counter
module lab61soc_button_poller
  import lab61soc_pkg::*;
#(
  parameter int POLL_DIV = DEF_POLL_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int ACTIVE_LOW = DEF_ACTIVE_LOW,
  parameter logic [1:0] POLL_ADDR = DEF_POLL_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear_count,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        pressed,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic [7:0]  press_count
);
  localparam int TW = $clog2(POLL_DIV);
  localparam logic [TW-1:0] LAST = TW'(POLL_DIV - 1);
  logic [1:0] state;
  logic [1:0] next_state;
  logic [TW-1:0] timer;
  logic sample;
  logic unused_bits;
  // a started transaction always completes; enable only gates the launch
  always_comb next_state = (state == READ) ? CAPTURE : (state == CAPTURE) ? IDLE : (enable && timer == LAST) ? READ : IDLE;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
      press_count <= 8'd0;
    end else begin
      state <= next_state;
      if (enable) timer <= (timer == LAST) ? '0 : timer + 1'b1;
      press_count <= clear_count ? {7'd0, press_pulse} : press_count + {7'd0, press_pulse};
    end
  end
  assign avm_read = state == READ;
  assign avm_address = avm_read ? POLL_ADDR : 2'd0;
  assign sample = avm_readdata[0] ^ (ACTIVE_LOW != 0);
  assign unused_bits = ^avm_readdata[31:1];
  lab61soc_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_debounce (
    .clk(clk),
    .reset_n(reset_n),
    .sample_valid(state == CAPTURE),
    .sample(sample),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );
endmodule

// File: tb/tb_lab61soc_button_poller.sv
// tb_lab61soc_button_poller: scoreboard bench driving a latency-1 button slave
module tb_lab61soc_button_poller;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic clear_count = 1'b0;
  logic btn = 1'b1;
  logic [1:0] avm_address;
  logic avm_read;
  logic [31:0] avm_readdata = 32'd0;
  logic pressed, press_pulse, release_pulse;
  logic [7:0] press_count;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rd = -100;
  bit chk_period = 1'b0;
  bit have_last = 1'b0;
  typedef struct {bit press; logic [7:0] cnt;} exp_t;
  exp_t q[$];

  lab61soc_button_poller #(.POLL_DIV(4), .STABLE_SAMPLES(3), .ACTIVE_LOW(1), .POLL_ADDR(2'd0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear_count(clear_count),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  // slave: data returned one cycle after the read strobe, upper bits are noise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_read) avm_readdata <= {31'h2AAAAAAA, btn};
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input bit p, input logic [7:0] c);
    exp_t e;
    e.press = p;
    e.cnt = c;
    q.push_back(e);
  endtask

  task automatic wait_read(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avm_read && n < 40);
    if (!avm_read) chk("read_timeout", 0, 1);
  endtask

  task automatic poll(input bit b);
    int n;
    wait_read(n);
    btn = b;
    @(negedge clk);
  endtask

  task automatic do_press(input logic [7:0] c);
    expect_pulse(1'b1, c);
    repeat (3) poll(1'b0);
  endtask

  task automatic do_release(input logic [7:0] c);
    expect_pulse(1'b0, c);
    repeat (3) poll(1'b1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_pressed"}, pressed, 0);
    chk({name, "_press_pulse"}, press_pulse, 0);
    chk({name, "_release_pulse"}, release_pulse, 0);
    chk({name, "_count"}, press_count, 0);
    chk({name, "_read"}, avm_read, 0);
    chk({name, "_addr"}, avm_address, 0);
  endtask

  initial begin : monitor
    exp_t e;
    bit pend;
    logic [7:0] pend_cnt;
    pend = 1'b0;
    pend_cnt = 8'd0;
    forever begin
      @(negedge clk);
      chk("addr", avm_address, 0);
      if (pend) begin
        chk("count", press_count, pend_cnt);
        pend = 1'b0;
      end
      if (avm_read) begin
        if (chk_period && have_last) chk("period", cyc - last_rd, 4);
        last_rd = cyc;
        have_last = 1'b1;
      end
      if (press_pulse || release_pulse) begin
        chk("one_pulse", press_pulse && release_pulse, 0);
        if (q.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          e = q.pop_front();
          chk("pulse_kind", press_pulse, e.press);
          chk("pressed", pressed, e.press);
          chk("latency", cyc - last_rd, 2);
          pend = 1'b1;
          pend_cnt = e.cnt;
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    enable = 1'b1;
    chk_period = 1'b1;
    repeat (4) poll(1'b1);
    do_press(8'd1);
    do_release(8'd1);
    poll(1'b0); poll(1'b1); poll(1'b0); poll(1'b0); poll(1'b1);
    do_press(8'd2);
    for (int i = 3; i <= 255; i++) begin
      do_release(8'(i - 1));
      do_press(8'(i));
    end
    do_release(8'd255);
    do_press(8'd0);
    do_release(8'd0);
    expect_pulse(1'b1, 8'd1);
    repeat (3) poll(1'b0);
    @(posedge clk); #1 clear_count = 1'b1;
    repeat (2) @(posedge clk);
    #1 clear_count = 1'b0;
    @(negedge clk);
    chk("clear_alone", press_count, 0);
    chk_period = 1'b0;
    poll(1'b1); poll(1'b1);
    expect_pulse(1'b0, 8'd0);
    wait_read(n);
    btn = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (avm_read) n++;
    end
    chk("hold_idle", n, 0);
    enable = 1'b1;
    wait_read(n);
    chk("resume_read", n, 4);
    btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    wait_read(n);
    chk("resume_held", n, 2);
    btn = 1'b1;
    @(negedge clk);
    do_press(8'd1);
    poll(1'b1); poll(1'b1);
    wait_read(n);
    btn = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    wait_read(n);
    chk("first_read_after_reset", n, 4);
    btn = 1'b1;
    repeat (6) @(negedge clk);
    chk("after_reset_pressed", pressed, 0);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/lab61soc_button_poller.md
LAB61SOC_BUTTON_POLLER -- requirements
Module: lab61soc_button_poller

Interface
REQ-001 SHALL have parameter POLL_DIV, default 50000, poll period in clk cycles (legal ≥ 3).
REQ-002 SHALL have parameter STABLE_SAMPLES, default 4, consecutive equal samples needed to accept a level (legal 1..15).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 means readdata bit 0 = 0 is "pressed".
REQ-004 SHALL have parameter POLL_ADDR, default 2'd0, the address of the button data register.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset, synchronous and active-low.
REQ-007 enable  input  1  polling enable.
REQ-008 clear_count  input  1  one-cycle request to zero press_count.
REQ-009 avm_address  output  2  Avalon-MM read address.
REQ-010 avm_read  output  1  Avalon-MM read strobe.
REQ-011 avm_readdata  input  32  read data, fixed read latency 1, no waitrequest.
REQ-012 pressed  output  1  debounced button state, 1 = pressed.
REQ-013 press_pulse  output  1  one-cycle pulse on accepted press.
REQ-014 release_pulse  output  1  one-cycle pulse on accepted release.
REQ-015 press_count  output  8  count of accepted presses.

Function
REQ-016 SHALL act as the Avalon-MM initiator reading the button register; avm_address SHALL equal POLL_ADDR whenever avm_read = 1 and 0 otherwise.
REQ-017 FSM states: IDLE, READ, CAPTURE.
REQ-018 Free-running timer 0..POLL_DIV-1 SHALL advance every cycle while enable = 1 and hold while enable = 0.
REQ-019 IDLE -> READ when the timer equals POLL_DIV-1 and enable = 1; otherwise stay in IDLE.
REQ-020 READ: avm_read = 1 for exactly one cycle; READ -> CAPTURE unconditionally.
REQ-021 CAPTURE: sample avm_readdata[0] (inverted if ACTIVE_LOW) at the end of the cycle; CAPTURE -> IDLE unconditionally.
REQ-022 Poll period SHALL be exactly POLL_DIV cycles; bits 31:1 of readdata SHALL be ignored.
REQ-023 Debounce: sample equal to candidate -> stable_cnt increments, saturating at STABLE_SAMPLES; sample different -> candidate := sample, stable_cnt := 1.
REQ-024 When stable_cnt (after update) equals STABLE_SAMPLES and candidate != pressed, pressed SHALL update one cycle after CAPTURE.
REQ-025 press_pulse or release_pulse SHALL be high in that same cycle, for exactly one cycle; never both.
REQ-026 press_count SHALL increment on each press_pulse and wrap from 255 to 0.
REQ-027 clear_count coincident with press_pulse SHALL yield press_count = 1; clear_count alone SHALL yield 0 on the next cycle.
REQ-028 enable deasserted during READ or CAPTURE SHALL let the transaction complete and its sample be processed; the FSM then holds in IDLE.

Reset
REQ-029 reset_n = 0 at a rising edge SHALL force: state IDLE, timer 0, avm_read 0, avm_address 0, pressed 0, both pulses 0, press_count 0, candidate 0, stable_cnt 0.
REQ-030 Reset mid-transaction SHALL abandon the read; readdata returned afterwards SHALL be ignored.

Structure
REQ-031 State encoding and default parameter constants SHALL reside in the shared package lab61soc_pkg.
REQ-032 Debounce logic (candidate, stable_cnt, pressed, pulses) SHALL be a single sub-module, lab61soc_debounce, fed by a sample_valid/sample pair.

Verification (POLL_DIV=4, STABLE_SAMPLES=3, ACTIVE_LOW=1, slave model with latency 1)
REQ-033 Reset, enable=1, readdata=1 held -> avm_read pulses every 4 cycles at address 0; pressed stays 0; no pulses.
REQ-034 readdata 1->0 held -> pressed=1 one cycle after the 3rd consecutive 0-sample CAPTURE; press_pulse is high for 1 cycle; press_count=1.
REQ-035 Bounce 0,1,0,0,1 samples -> no pressed change, no pulses; then 0,0,0 -> one press_pulse.
REQ-036 Preload 255 presses, then one press -> press_count=0; clear_count coincident with a press_pulse -> press_count=1.
REQ-037 enable dropped in the READ cycle -> CAPTURE still occurs, then no further avm_read until enable=1; timer resumes from its held value.
REQ-038 reset_n=0 asserted in CAPTURE -> all outputs 0 next cycle; first avm_read issued 4 cycles after reset_n returns to 1.
